sram_arbiter: RTL

Sequencer and three-port arbiter for the board's external asynchronous SRAM (21-bit address, 8-bit data lane). It sits between the chipset-side requesters and the SRAM pins in the `system_2MB` hierarchy. Port 0 (video refresh) has absolute priority; ports 1 (CPU/chipset) and 2 (SD/DMA loader) share the remaining slots round-robin. The block owns all SRAM control-pin timing; the top level only builds the tristate from `sram_data_oe`.

---
 rtl/sram_arb_pkg.sv | 25 ++
 rtl/sram_arbiter_if.sv | 42 ++++
 rtl/sram_rr_pick.sv | 28 ++
 rtl/sram_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the external SRAM sequencer/arbiter.
// Ports: video (fixed priority), CPU and DMA (round-robin between them).
package sram_arb_pkg;

    localparam int unsigned ADDR_W_DEF      = 21;
    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned WAIT_CYCLES_DEF = 2;
    localparam int unsigned NUM_PORTS       = 3;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned PORT_IDX_W      = 2;

    localparam int unsigned PORT_VID = 0;
    localparam int unsigned PORT_CPU = 1;
    localparam int unsigned PORT_DMA = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    typedef logic [PORT_IDX_W-1:0] port_idx_t;
    typedef logic [NUM_PORTS-1:0]  port_vec_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle for the three SRAM ports.
// The master modport is the requester, the slave modport is the arbiter.
interface sram_arbiter_if #(
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned DATA_W = 8
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic [DATA_W-1:0] p1_rdata;

    logic              p2_req;
    logic              p2_we;
    logic [ADDR_W-1:0] p2_addr;
    logic [DATA_W-1:0] p2_wdata;
    logic              p2_ack;
    logic [DATA_W-1:0] p2_rdata;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output p2_req, p2_we, p2_addr, p2_wdata,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata, p2_ack, p2_rdata
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  p2_req, p2_we, p2_addr, p2_wdata,
        output p0_ack, p0_rdata, p1_ack, p1_rdata, p2_ack, p2_rdata
    );

endinterface

// File: rtl/sram_rr_pick.sv
// Combinational grant selector: video port wins outright, CPU/DMA alternate
// on a tie based on which of them was served last.
module sram_rr_pick
    import sram_arb_pkg::*;
(
    input  port_vec_t req,
    input  port_idx_t rr_last,
    output port_vec_t gnt_c
);

    always_comb begin
        gnt_c = '0;
        if (req[PORT_VID]) begin
            gnt_c[PORT_VID] = 1'b1;
        end else if (req[PORT_CPU] && req[PORT_DMA]) begin
            if (rr_last == port_idx_t'(PORT_CPU)) begin
                gnt_c[PORT_DMA] = 1'b1;
            end else begin
                gnt_c[PORT_CPU] = 1'b1;
            end
        end else if (req[PORT_CPU]) begin
            gnt_c[PORT_CPU] = 1'b1;
        end else if (req[PORT_DMA]) begin
            gnt_c[PORT_DMA] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Three-port arbiter and control-pin sequencer for the asynchronous SRAM.
// Every access is IDLE -> ACCESS (WAIT_CYCLES clocks) -> RECOVER (1 clock).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk_chipset,
    input  logic              reset,
    sram_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_data_o,
    input  logic [DATA_W-1:0] sram_data_i,
    output logic              sram_data_oe,
    output logic              sram_we_n,
    output logic              sram_oe_n
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    port_vec_t         gnt_q, gnt_d;
    port_idx_t         rr_last_q, rr_last_d;
    logic              we_q, we_d;
    port_vec_t         ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q [NUM_PORTS];
    logic [DATA_W-1:0] rdata_d [NUM_PORTS];

    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              data_oe_d;
    logic              we_n_d;
    logic              oe_n_d;

    port_vec_t         req_c;
    port_vec_t         gnt_c;
    logic              sel_we_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;

    assign req_c = {bus.p2_req, bus.p1_req, bus.p0_req};

    sram_rr_pick u_pick (
        .req     (req_c),
        .rr_last (rr_last_q),
        .gnt_c   (gnt_c)
    );

    // Fields of the port that the selector just granted.
    always_comb begin
        sel_we_c    = bus.p0_we;
        sel_addr_c  = bus.p0_addr;
        sel_wdata_c = bus.p0_wdata;
        if (gnt_c[PORT_CPU]) begin
            sel_we_c    = bus.p1_we;
            sel_addr_c  = bus.p1_addr;
            sel_wdata_c = bus.p1_wdata;
        end else if (gnt_c[PORT_DMA]) begin
            sel_we_c    = bus.p2_we;
            sel_addr_c  = bus.p2_addr;
            sel_wdata_c = bus.p2_wdata;
        end
    end

    // Next-state and next-pin logic; every pin is registered from these.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        rr_last_d = rr_last_q;
        we_d      = we_q;
        ack_d     = '0;
        rdata_d   = rdata_q;
        addr_d    = sram_addr;
        wdata_d   = sram_data_o;
        data_oe_d = sram_data_oe;
        we_n_d    = sram_we_n;
        oe_n_d    = sram_oe_n;

        case (state_q)
            ST_IDLE: begin
                data_oe_d = 1'b0;
                we_n_d    = 1'b1;
                oe_n_d    = 1'b1;
                if (gnt_c != '0) begin
                    gnt_d     = gnt_c;
                    we_d      = sel_we_c;
                    addr_d    = sel_addr_c;
                    wdata_d   = sel_wdata_c;
                    cnt_d     = CNT_W'(WAIT_CYCLES - 1);
                    data_oe_d = sel_we_c;
                    we_n_d    = ~sel_we_c;
                    oe_n_d    = sel_we_c;
                    state_d   = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    // Strobes release here; data_oe is held through RECOVER.
                    we_n_d = 1'b1;
                    oe_n_d = 1'b1;
                    ack_d  = gnt_q;
                    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                        if (gnt_q[i] && !we_q) begin
                            rdata_d[i] = sram_data_i;
                        end
                    end
                    state_d = ST_RECOVER;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_RECOVER: begin
                if (gnt_q[PORT_CPU]) begin
                    rr_last_d = port_idx_t'(PORT_CPU);
                end else if (gnt_q[PORT_DMA]) begin
                    rr_last_d = port_idx_t'(PORT_DMA);
                end
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_chipset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            gnt_q        <= '0;
            rr_last_q    <= port_idx_t'(PORT_DMA);
            we_q         <= 1'b0;
            ack_q        <= '0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                rdata_q[i] <= '0;
            end
            sram_addr    <= '0;
            sram_data_o  <= '0;
            sram_data_oe <= 1'b0;
            sram_we_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            rr_last_q    <= rr_last_d;
            we_q         <= we_d;
            ack_q        <= ack_d;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                rdata_q[i] <= rdata_d[i];
            end
            sram_addr    <= addr_d;
            sram_data_o  <= wdata_d;
            sram_data_oe <= data_oe_d;
            sram_we_n    <= we_n_d;
            sram_oe_n    <= oe_n_d;
        end
    end

    assign bus.p0_ack   = ack_q[PORT_VID];
    assign bus.p1_ack   = ack_q[PORT_CPU];
    assign bus.p2_ack   = ack_q[PORT_DMA];
    assign bus.p0_rdata = rdata_q[PORT_VID];
    assign bus.p1_rdata = rdata_q[PORT_CPU];
    assign bus.p2_rdata = rdata_q[PORT_DMA];

endmodule
